// File: rtl/similarity_check_param.sv
// similarity_check_param: accumulates per-chunk bit-similarity scores over a frame and flags score > thr.
// Define SIMILARITY_ACC_OUT_EN to expose the final accumulator on acc_out.
module similarity_check_param #(
  parameter int DATA_W = 1024,
  parameter int NUM_W = 8,
  parameter int ACC_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_W-1:0]  count,
  input  logic [ACC_W-1:0]  thr,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] xt,
  input  logic [DATA_W-1:0] xt_1,
  output logic              busy,
  output logic              similarity_flag,
  output logic              SM_done
`ifdef SIMILARITY_ACC_OUT_EN
  ,
  output logic [ACC_W-1:0]  acc_out
`endif
);
  localparam int SW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [NUM_W-1:0] tgt, cnt;
  logic [ACC_W-1:0] thr_q, acc, acc_nxt;
  logic [ACC_W:0] sum;
  logic [SW-1:0] score, score_q;
  logic [DATA_W-1:0] hit;
  logic mode_q, go, xfer, last;
  assign go = start && (state == IDLE || state == DONE);
  assign in_ready = state == RUN;
  assign busy = state == RUN || state == DRAIN;
  assign xfer = in_valid && in_ready;
  assign last = cnt == tgt - NUM_W'(1);
  assign hit = mode_q ? xt & xt_1 : ~(xt ^ xt_1);
  assign sum = {1'b0, acc} + (ACC_W + 1)'(score_q);
  assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`ifdef SIMILARITY_ACC_OUT_EN
  assign acc_out = SM_done ? acc : '0;
`endif
  always_comb begin
    score = '0;
    for (int i = 0; i < DATA_W; i++) score = score + SW'(hit[i]);
  end
  always_comb begin
    nxt = state;
    if (go) nxt = count == '0 ? DRAIN : RUN;
    else if (state == RUN && xfer && last) nxt = DRAIN;
    else if (state == DRAIN) nxt = DONE;
  end
  // score_q is zero on idle cycles, so accumulating every cycle leaves acc stable outside a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tgt <= '0;
      cnt <= '0;
      thr_q <= '0;
      mode_q <= 1'b0;
      acc <= '0;
      score_q <= '0;
      similarity_flag <= 1'b0;
      SM_done <= 1'b0;
    end else begin
      state <= nxt;
      score_q <= xfer ? score : '0;
      if (go) begin
        tgt <= count;
        thr_q <= thr;
        mode_q <= mode;
        cnt <= '0;
        acc <= '0;
        SM_done <= 1'b0;
      end else begin
        acc <= acc_nxt;
        if (xfer) cnt <= cnt + NUM_W'(1);
        if (state == DRAIN) begin
          similarity_flag <= acc_nxt > thr_q;
          SM_done <= 1'b1;
        end
      end
    end
  end
endmodule
